// File: rtl/axi_rd_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : axi_rd_arbiter
// Purpose  : Two-port AXI4 read arbiter. The grant is held per burst, and the
//            port-0 urgent hint overrides round-robin fairness.
// Revision : 1.0 - initial release
// ============================================================================
module axi_rd_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic [ADDR_WIDTH-1:0] s0_araddr,
  input  logic [7:0]            s0_arlen,
  input  logic [2:0]            s0_arsize,
  input  logic [1:0]            s0_arburst,
  input  logic                  s0_arvalid,
  output logic                  s0_arready,
  output logic [DATA_WIDTH-1:0] s0_rdata,
  output logic [1:0]            s0_rresp,
  output logic                  s0_rlast,
  output logic                  s0_rvalid,
  input  logic                  s0_rready,
  input  logic                  s0_urgent,

  input  logic [ADDR_WIDTH-1:0] s1_araddr,
  input  logic [7:0]            s1_arlen,
  input  logic [2:0]            s1_arsize,
  input  logic [1:0]            s1_arburst,
  input  logic                  s1_arvalid,
  output logic                  s1_arready,
  output logic [DATA_WIDTH-1:0] s1_rdata,
  output logic [1:0]            s1_rresp,
  output logic                  s1_rlast,
  output logic                  s1_rvalid,
  input  logic                  s1_rready,

  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]            m_axi_arlen,
  output logic [2:0]            m_axi_arsize,
  output logic [1:0]            m_axi_arburst,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic [DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rlast,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready,

  output logic                  grant,
  output logic                  busy,
  output logic                  protocol_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  r_grant;
  logic                  r_last_grant;
  logic                  r_protocol_err;
  logic [7:0]            r_beat_ctr;
  logic [ADDR_WIDTH-1:0] r_araddr;
  logic [7:0]            r_arlen;
  logic [2:0]            r_arsize;
  logic [1:0]            r_arburst;
  logic                  r_arvalid;

  logic                  w_req;
  logic                  w_winner;
  logic                  w_beat;
  logic                  w_len_hit;

  assign w_req     = s0_arvalid | s1_arvalid;
  assign w_beat    = (r_state == DATA) && m_axi_rvalid && m_axi_rready;
  assign w_len_hit = (r_beat_ctr == r_arlen);

  // Urgent beats fairness; a tie goes to the port that did not win last time.
  always_comb begin
    w_winner = 1'b0;
    if (s0_urgent && s0_arvalid) begin
      w_winner = 1'b0;
    end else if (s0_arvalid && s1_arvalid) begin
      w_winner = ~r_last_grant;
    end else if (s1_arvalid) begin
      w_winner = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    s0_arready   = 1'b0;
    s1_arready   = 1'b0;
    s0_rvalid    = 1'b0;
    s1_rvalid    = 1'b0;
    m_axi_rready = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_req) begin
          s0_arready  = ~w_winner;
          s1_arready  = w_winner;
          w_state_nxt = ADDR;
        end
      end
      ADDR: begin
        if (m_axi_arready) begin
          w_state_nxt = DATA;
        end
      end
      DATA: begin
        s0_rvalid    = m_axi_rvalid & ~r_grant;
        s1_rvalid    = m_axi_rvalid &  r_grant;
        m_axi_rready = r_grant ? s1_rready : s0_rready;
        if (w_beat && m_axi_rlast) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_grant        <= 1'b0;
      r_last_grant   <= 1'b1;
      r_protocol_err <= 1'b0;
      r_beat_ctr     <= 8'd0;
      r_araddr       <= '0;
      r_arlen        <= 8'd0;
      r_arsize       <= 3'd0;
      r_arburst      <= 2'd0;
      r_arvalid      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_req) begin
            r_grant    <= w_winner;
            r_beat_ctr <= 8'd0;
            r_arvalid  <= 1'b1;
            r_araddr   <= w_winner ? s1_araddr  : s0_araddr;
            r_arlen    <= w_winner ? s1_arlen   : s0_arlen;
            r_arsize   <= w_winner ? s1_arsize  : s0_arsize;
            r_arburst  <= w_winner ? s1_arburst : s0_arburst;
          end
        end
        ADDR: begin
          if (m_axi_arready) begin
            r_arvalid <= 1'b0;
          end
        end
        DATA: begin
          if (w_beat) begin
            r_beat_ctr <= r_beat_ctr + 8'd1;
            // rlast must coincide exactly with the beat numbered arlen
            if (m_axi_rlast != w_len_hit) begin
              r_protocol_err <= 1'b1;
            end
            if (m_axi_rlast) begin
              r_last_grant <= r_grant;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign m_axi_araddr  = r_araddr;
  assign m_axi_arlen   = r_arlen;
  assign m_axi_arsize  = r_arsize;
  assign m_axi_arburst = r_arburst;
  assign m_axi_arvalid = r_arvalid;

  assign s0_rdata = m_axi_rdata;
  assign s0_rresp = m_axi_rresp;
  assign s0_rlast = m_axi_rlast;
  assign s1_rdata = m_axi_rdata;
  assign s1_rresp = m_axi_rresp;
  assign s1_rlast = m_axi_rlast;

  assign grant        = r_grant;
  assign busy         = (r_state != IDLE);
  assign protocol_err = r_protocol_err;

endmodule
`default_nettype wire

// File: tb/tb_axi_rd_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_rd_arbiter
// Purpose  : Directed self-checking bench for axi_rd_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi_rd_arbiter;

  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 32;

  logic                  clk = 1'b0;
  logic                  rst = 1'b0;
  logic [ADDR_WIDTH-1:0] s0_araddr = '0, s1_araddr = '0;
  logic [7:0]            s0_arlen = '0, s1_arlen = '0;
  logic [2:0]            s0_arsize = 3'd2, s1_arsize = 3'd2;
  logic [1:0]            s0_arburst = 2'd1, s1_arburst = 2'd1;
  logic                  s0_arvalid = 1'b0, s1_arvalid = 1'b0;
  logic                  s0_arready, s1_arready;
  logic [DATA_WIDTH-1:0] s0_rdata, s1_rdata;
  logic [1:0]            s0_rresp, s1_rresp;
  logic                  s0_rlast, s1_rlast;
  logic                  s0_rvalid, s1_rvalid;
  logic                  s0_rready = 1'b0, s1_rready = 1'b0;
  logic                  s0_urgent = 1'b0;
  logic [ADDR_WIDTH-1:0] m_axi_araddr;
  logic [7:0]            m_axi_arlen;
  logic [2:0]            m_axi_arsize;
  logic [1:0]            m_axi_arburst;
  logic                  m_axi_arvalid;
  logic                  m_axi_arready = 1'b0;
  logic [DATA_WIDTH-1:0] m_axi_rdata = '0;
  logic [1:0]            m_axi_rresp = 2'd0;
  logic                  m_axi_rlast = 1'b0;
  logic                  m_axi_rvalid = 1'b0;
  logic                  m_axi_rready;
  logic                  grant, busy, protocol_err;

  int n_assert = 0;
  int n_fail   = 0;

  axi_rd_arbiter #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) dut (
    .clk(clk), .rst(rst),
    .s0_araddr(s0_araddr), .s0_arlen(s0_arlen), .s0_arsize(s0_arsize),
    .s0_arburst(s0_arburst), .s0_arvalid(s0_arvalid), .s0_arready(s0_arready),
    .s0_rdata(s0_rdata), .s0_rresp(s0_rresp), .s0_rlast(s0_rlast),
    .s0_rvalid(s0_rvalid), .s0_rready(s0_rready), .s0_urgent(s0_urgent),
    .s1_araddr(s1_araddr), .s1_arlen(s1_arlen), .s1_arsize(s1_arsize),
    .s1_arburst(s1_arburst), .s1_arvalid(s1_arvalid), .s1_arready(s1_arready),
    .s1_rdata(s1_rdata), .s1_rresp(s1_rresp), .s1_rlast(s1_rlast),
    .s1_rvalid(s1_rvalid), .s1_rready(s1_rready),
    .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
    .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid),
    .m_axi_rready(m_axi_rready),
    .grant(grant), .busy(busy), .protocol_err(protocol_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, expected finish before timeout");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic last);
    m_axi_rvalid = 1'b1;
    m_axi_rlast  = last;
    tick();
    m_axi_rvalid = 1'b0;
    m_axi_rlast  = 1'b0;
  endtask

  // Entered in IDLE with requests already driven; leaves in the post-rlast IDLE cycle.
  task automatic run_burst(input logic port, input int nbeats, input logic [31:0] addr);
    #1;
    chk("arready_win",  port ? s1_arready : s0_arready, 1);
    chk("arready_lose", port ? s0_arready : s1_arready, 0);
    tick();
    chk("arready_gone", {s0_arready, s1_arready}, 0);
    chk("grant", grant, port);
    chk("busy_addr", busy, 1);
    chk("m_arvalid", m_axi_arvalid, 1);
    chk("m_araddr", m_axi_araddr, addr);
    chk("m_arlen", m_axi_arlen, nbeats - 1);
    m_axi_arready = 1'b1;
    tick();
    m_axi_arready = 1'b0;
    chk("m_arvalid_drop", m_axi_arvalid, 0);
    s0_rready = 1'b1;
    s1_rready = 1'b1;
    for (int i = 0; i < nbeats; i++) begin
      m_axi_rvalid = 1'b1;
      m_axi_rdata  = 32'hA000 + i;
      m_axi_rlast  = (i == nbeats - 1);
      #1;
      chk("rvalid_grant", port ? s1_rvalid : s0_rvalid, 1);
      chk("rvalid_other", port ? s0_rvalid : s1_rvalid, 0);
      chk("rdata", port ? s1_rdata : s0_rdata, 32'hA000 + i);
      chk("busy_data", busy, 1);
      tick();
    end
    m_axi_rvalid = 1'b0;
    m_axi_rlast  = 1'b0;
    chk("idle_bubble", busy, 0);
    chk("perr_clean", protocol_err, 0);
  endtask

  initial begin
    int acc;

    // Reset state
    tick(); tick();
    chk("rst_busy", busy, 0);
    chk("rst_arvalid", m_axi_arvalid, 0);
    chk("rst_araddr", m_axi_araddr, 0);
    chk("rst_grant", grant, 0);
    chk("rst_perr", protocol_err, 0);
    chk("rst_rready", m_axi_rready, 0);
    rst = 1'b1;
    tick();

    // Single request on port 1
    s1_araddr = 32'h1000; s1_arlen = 8'd15; s1_arvalid = 1'b1;
    run_burst(1'b1, 16, 32'h1000);
    s1_arvalid = 1'b0;
    chk("single_grant_hold", grant, 1);

    // Tie, no urgent: 0,1,0,1 then a 5th burst to port 0
    s0_araddr = 32'h2000; s0_arlen = 8'd31; s0_arvalid = 1'b1;
    s1_araddr = 32'h3000; s1_arlen = 8'd31; s1_arvalid = 1'b1;
    run_burst(1'b0, 32, 32'h2000);
    run_burst(1'b1, 32, 32'h3000);
    run_burst(1'b0, 32, 32'h2000);
    run_burst(1'b1, 32, 32'h3000);
    s0_arlen = 8'd3; s1_arlen = 8'd3;
    run_burst(1'b0, 4, 32'h2000);

    // Urgent beats round-robin preference for port 1
    s0_urgent = 1'b1;
    run_burst(1'b0, 4, 32'h2000);
    run_burst(1'b0, 4, 32'h2000);
    s0_urgent = 1'b0;
    run_burst(1'b1, 4, 32'h3000);
    s0_arvalid = 1'b0; s1_arvalid = 1'b0;

    // Backpressure on AR then on R
    s0_araddr = 32'h4444; s0_arlen = 8'd7; s0_arvalid = 1'b1;
    #1;
    chk("bp_arready", s0_arready, 1);
    tick();
    s0_arvalid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk("bp_ar_hold_addr", m_axi_araddr, 32'h4444);
      chk("bp_ar_hold_valid", m_axi_arvalid, 1);
      chk("bp_ar_hold_len", m_axi_arlen, 7);
      tick();
    end
    m_axi_arready = 1'b1;
    tick();
    m_axi_arready = 1'b0;
    acc = 0;
    for (int k = 0; k < 40; k++) begin
      s0_rready    = k[0];
      m_axi_rvalid = 1'b1;
      m_axi_rdata  = 32'hB000 + acc;
      m_axi_rlast  = (acc == 7);
      #1;
      chk("bp_rready_mirror", m_axi_rready, k[0]);
      chk("bp_rvalid", s0_rvalid, 1);
      chk("bp_rdata", s0_rdata, 32'hB000 + acc);
      chk("bp_busy", busy, 1);
      tick();
      if (k[0]) acc++;
      if (acc == 8) break;
    end
    m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0; s0_rready = 1'b1;
    chk("bp_done", busy, 0);
    chk("bp_perr", protocol_err, 0);

    // Early rlast: arlen 3 with rlast on beat 2
    s1_araddr = 32'h5000; s1_arlen = 8'd3; s1_arvalid = 1'b1;
    #1;
    chk("pe1_arready", s1_arready, 1);
    tick();
    s1_arvalid = 1'b0;
    m_axi_arready = 1'b1; tick(); m_axi_arready = 1'b0;
    send_beat(1'b0);
    send_beat(1'b0);
    chk("pe1_before", protocol_err, 0);
    send_beat(1'b1);
    chk("pe1_set", protocol_err, 1);
    chk("pe1_idle", busy, 0);

    // Missing rlast on beat 4 of arlen 3
    s0_araddr = 32'h5100; s0_arlen = 8'd3; s0_arvalid = 1'b1;
    #1;
    chk("pe2_arready", s0_arready, 1);
    tick();
    s0_arvalid = 1'b0;
    m_axi_arready = 1'b1; tick(); m_axi_arready = 1'b0;
    for (int i = 0; i < 4; i++) send_beat(1'b0);
    chk("pe2_sticky", protocol_err, 1);
    chk("pe2_still_busy", busy, 1);
    send_beat(1'b1);
    chk("pe2_idle", busy, 0);
    chk("pe2_sticky2", protocol_err, 1);

    // Reset during beat 5 of 32
    s1_araddr = 32'h6000; s1_arlen = 8'd31; s1_arvalid = 1'b1;
    #1;
    chk("rm_arready", s1_arready, 1);
    tick();
    s1_arvalid = 1'b0;
    m_axi_arready = 1'b1; tick(); m_axi_arready = 1'b0;
    for (int i = 0; i < 5; i++) send_beat(1'b0);
    m_axi_rvalid = 1'b1;
    rst = 1'b0;
    tick();
    chk("rm_busy", busy, 0);
    chk("rm_grant", grant, 0);
    chk("rm_arvalid", m_axi_arvalid, 0);
    chk("rm_araddr", m_axi_araddr, 0);
    chk("rm_arlen", m_axi_arlen, 0);
    chk("rm_perr", protocol_err, 0);
    chk("rm_rready", m_axi_rready, 0);
    chk("rm_rvalid", {s0_rvalid, s1_rvalid}, 0);
    rst = 1'b1;
    m_axi_rvalid = 1'b0;

    // Fresh tie after reset goes to port 0; arlen 0 without rlast flags an error
    s0_araddr = 32'h7000; s0_arlen = 8'd0; s0_arvalid = 1'b1;
    s1_araddr = 32'h7100; s1_arlen = 8'd0; s1_arvalid = 1'b1;
    #1;
    chk("fr_arready0", s0_arready, 1);
    chk("fr_arready1", s1_arready, 0);
    tick();
    s0_arvalid = 1'b0; s1_arvalid = 1'b0;
    chk("fr_grant", grant, 0);
    chk("fr_araddr", m_axi_araddr, 32'h7000);
    m_axi_arready = 1'b1; tick(); m_axi_arready = 1'b0;
    send_beat(1'b0);
    chk("len0_perr", protocol_err, 1);
    chk("len0_busy", busy, 1);
    send_beat(1'b1);
    chk("len0_idle", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
